// File: rtl/alu_pkg.sv
// Shared types and constants for the 4-bit board ALU command path.
// Holds the sequencer state encoding, the op codes and the datapath widths.
package alu_pkg;

    localparam int DATA_W = 4;
    localparam int OP_W   = 3;

    // The encoding is also shown on the state LEDs, so the values are fixed.
    typedef enum logic [2:0] {
        S_A     = 3'd0,
        S_B     = 3'd1,
        S_OP    = 3'd2,
        S_ISSUE = 3'd3,
        S_SHOW  = 3'd4
    } state_t;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_NOT = 3'b010;
    localparam logic [OP_W-1:0] OP_AND = 3'b011;
    localparam logic [OP_W-1:0] OP_OR  = 3'b100;
    localparam logic [OP_W-1:0] OP_XOR = 3'b101;
    localparam logic [OP_W-1:0] OP_LT  = 3'b110;
    localparam logic [OP_W-1:0] OP_EQ  = 3'b111;

endpackage

// File: rtl/btn_debounce.sv
// Button synchronizer and counter-based debouncer.
// Produces a clean level and a one-cycle pulse on each debounced press.
module btn_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   mismatch;
    logic                   expire;

    assign mismatch = sync_q[SYNC_STAGES-1] ^ level;
    // The level flips on the same edge that would have taken the counter past its limit.
    assign expire   = mismatch && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            cnt    <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            if (!mismatch || expire) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (expire) begin
                level <= ~level;
            end
            press <= expire & ~level;
        end
    end

endmodule

// File: rtl/alu_cmd_seq.sv
// Staged A / B / op-code entry from one button and four switches, issued to
// the ALU over valid/ready, with the ALU result latched for the display.
module alu_cmd_seq
    import alu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_raw,
    input  logic              clr,
    input  logic [DATA_W-1:0] sw,
    input  logic              cmd_ready,
    input  logic [DATA_W-1:0] res_in,
    input  logic              car_in,
    input  logic              of_in,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_ctrl,
    output logic              cmd_valid,
    output logic [DATA_W-1:0] res_q,
    output logic              car_q,
    output logic              of_q,
    output logic              res_valid,
    output logic [2:0]        state_o
);

    // Handshake: the command (alu_a/alu_b/alu_ctrl) is offered while cmd_valid
    // is high and is held unchanged until a cycle with cmd_valid && cmd_ready,
    // which is the single cycle in which the result inputs are sampled.

    state_t state, state_nxt;
    logic   btn_level, btn_pulse, press;
    logic   ld_a, ld_b, ld_op, ld_res, drop_res;

    btn_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_raw),
        .level(btn_level),
        .press(btn_pulse)
    );

    // The pulse coincides with the debounced level going high.
    assign press = btn_pulse & btn_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_A;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ld_a      = 1'b0;
        ld_b      = 1'b0;
        ld_op     = 1'b0;
        ld_res    = 1'b0;
        drop_res  = 1'b0;
        if (clr) begin
            state_nxt = S_A;
        end else begin
            case (state)
                S_A:     if (press) begin ld_a  = 1'b1; state_nxt = S_B;     end
                S_B:     if (press) begin ld_b  = 1'b1; state_nxt = S_OP;    end
                S_OP:    if (press) begin ld_op = 1'b1; state_nxt = S_ISSUE; end
                S_ISSUE: if (cmd_ready) begin ld_res = 1'b1; state_nxt = S_SHOW; end
                S_SHOW:  if (press) begin drop_res = 1'b1; state_nxt = S_A;  end
                default: state_nxt = S_A;
            endcase
        end
    end

    assign cmd_valid = (state == S_ISSUE);
    assign state_o   = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ctrl  <= '0;
            res_q     <= '0;
            car_q     <= 1'b0;
            of_q      <= 1'b0;
            res_valid <= 1'b0;
        end else if (clr) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ctrl  <= '0;
            res_q     <= '0;
            car_q     <= 1'b0;
            of_q      <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            if (ld_a)  alu_a    <= sw;
            if (ld_b)  alu_b    <= sw;
            if (ld_op) alu_ctrl <= sw[OP_W-1:0];
            if (ld_res) begin
                res_q     <= res_in;
                car_q     <= car_in;
                of_q      <= of_in;
                res_valid <= 1'b1;
            end else if (drop_res) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_cmd_seq.md
Name: alu_cmd_seq

Overview:
- Upstream operand/command sequencer for the 4-bit board ALU.
- Turns one noisy "enter" button plus four data switches into a staged entry of A, then B, then the 3-bit op code.
- Presents the captured command to the ALU with a valid/ready handshake.
- Latches the ALU's res/car/of outputs for the display stage and holds them until the next entry begins.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive cycles the synchronized button must differ from its debounced level before that level flips (>=2).
SYNC_STAGES, 2, flip-flop stages in the button synchronizer (>=2).
CNT_W, $clog2(DEBOUNCE_CYCLES), width of the debounce counter (derived, not overridden).

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
btn_raw  input  1  raw asynchronous enter button, high = pressed
clr  input  1  synchronous abort, already clean, sampled every cycle
sw  input  4  data switches; sw[2:0] also carry the op code
cmd_ready  input  1  ALU side accepts the command (tie high for the combinational ALU)
res_in  input  4  ALU result
car_in  input  1  ALU carry
of_in  input  1  ALU overflow
alu_a  output  4  registered operand A
alu_b  output  4  registered operand B
alu_ctrl  output  3  registered op code
cmd_valid  output  1  command valid
res_q  output  4  latched result
car_q  output  1  latched carry
of_q  output  1  latched overflow
res_valid  output  1  latched result is valid
state_o  output  3  current FSM state encoding, for LEDs

Behaviour:
- Reset (async, active-high):
  - All outputs are 0.
  - Synchronizer, debounced level and debounce counter are 0.
  - FSM enters S_A.
- Debounce:
  - btn_raw passes through SYNC_STAGES flops.
  - The counter clears whenever sync output == debounced level; otherwise it increments.
  - At counter == DEBOUNCE_CYCLES-1 with the mismatch still present, the debounced level flips and the counter clears.
  - press is a registered one-cycle pulse on the debounced rising edge only. Releases produce no pulse.
  - press asserts after the (SYNC_STAGES+DEBOUNCE_CYCLES)th edge following the first edge that samples btn_raw high.
  - A glitch shorter than DEBOUNCE_CYCLES produces no pulse.
- FSM states and state_o encoding:
  - S_A = 0: on press, alu_a <= sw; go to S_B.
  - S_B = 1: on press, alu_b <= sw; go to S_OP.
  - S_OP = 2: on press, alu_ctrl <= sw[2:0]; go to S_ISSUE.
  - S_ISSUE = 3:
    - cmd_valid = 1, driven from state (registered).
    - On the cycle where cmd_valid && cmd_ready: res_q/car_q/of_q <= res_in/car_in/of_in; res_valid <= 1; go to S_SHOW.
    - Presses are ignored.
    - cmd_valid holds and alu_a/alu_b/alu_ctrl stay stable until the handshake completes.
  - S_SHOW = 4: on press, res_valid <= 0; go to S_A. alu_a/b/ctrl and res_q hold their values.
- Operand registers change only on their own capture edge. sw changes at any other time have no effect.
- clr:
  - Takes priority over press and over the handshake in every state.
  - Next state is S_A, res_valid <= 0, cmd_valid deasserts the next cycle.
  - alu_a/b/ctrl and res_q are cleared to 0.
- A press and a handshake in the same S_ISSUE cycle: the handshake wins and the press is dropped.
- Encodings 5-7 are unreachable; if reached, go to S_A.
- The debounce filter keeps running in all states, including during clr.

Decomposition:
- Shared package alu_pkg:
  - state typedef/localparams S_A..S_SHOW (3 bits).
  - ALU op-code localparams: ADD=000, SUB=001, NOT=010, AND=011, OR=100, XOR=101, LT=110, EQ=111.
  - Widths DATA_W=4, OP_W=3.
- One sub-module, btn_debounce:
  - Parameters SYNC_STAGES and DEBOUNCE_CYCLES.
  - Ports clk, rst, raw, level, press.
  - Reusable for other board buttons.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, cmd_ready=1):
- Reset mid-sequence: assert rst asynchronously while in S_B with alu_a=5 -> all outputs 0 immediately, state_o=0.
- Glitch rejection:
  - btn_raw high for 3 cycles then low -> no press, state_o stays 0.
  - btn_raw held high -> press fires exactly 6 edges after the first sampling edge.
- Full ADD: sw=0111 press, sw=0001 press, sw=000 press -> cmd_valid 1 cycle, then res_q=1000, car_q=0, of_q=1, res_valid=1, state_o=4.
- SUB with carry: A=0011, B=0001, op=001 -> res_q=0010, car_q=1, of_q=0. A following press returns to state_o=0 with res_valid=0.
- Backpressure: cmd_ready=0 for 10 cycles in S_ISSUE with A=1010, B=0101, op=101 -> cmd_valid and operands stable for all 10 cycles. Presses in that window are ignored. cmd_ready=1 -> res_q=1111.
- clr in S_ISSUE together with cmd_ready=1 -> no capture, res_valid=0, alu_a/b/ctrl=0, state_o=0.
